// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-port controller.
package regfile_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  // Controller phases: clear sweep after reset, then arbitrated writes.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One register-file write-port transaction.
  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } rf_wr_t;

  // Width of an index into n items; never zero so a single requester still has a port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   cand;

  // Scan N candidates starting at ptr; the first asserted request wins.
  always_comb begin
    // NOTE: every output and temporary gets a default before any branch so no latch is inferred.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the dual-port register file: clears every entry after
// reset, then shares the single write port among NREQ valid/ready requesters in
// round-robin order. All rf_* outputs are registered.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int AW      = RF_AW,
  parameter  int DW      = RF_DW,
  parameter  bit ZERO_R0 = 1'b1,
  localparam int IW      = idx_width(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rf_we,
  output logic [AW-1:0]     rf_wa,
  output logic [DW-1:0]     rf_wd,
  output logic [IW-1:0]     grant_id,
  output logic              init_done
);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   sweep_cnt;
  logic            sweep_last;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   win;
  logic            accept;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (win)
  );

  assign sweep_last = (sweep_cnt == {AW{1'b1}});
  assign win_addr   = req_addr[int'(win)*AW +: AW];
  assign win_data   = req_data[int'(win)*DW +: DW];
  assign ptr_nxt    = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);

  // Next state and handshake: requesters only see ready once the sweep is done.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (sweep_last) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        req_ready = gnt;
        accept    = |gnt;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  // Write-port registers, sweep counter and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep_cnt <= '0;
      ptr       <= '0;
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      grant_id  <= '0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        ST_INIT: begin
          // Clear sweep writes every address, including 0 even when ZERO_R0 is set.
          rf_we     <= 1'b1;
          rf_wa     <= sweep_cnt;
          rf_wd     <= '0;
          sweep_cnt <= sweep_cnt + AW'(1);
          if (sweep_last) init_done <= 1'b1;
        end
        ST_RUN: begin
          if (accept) begin
            // Writes to address 0 complete the handshake but never reach the file.
            rf_we    <= !(ZERO_R0 && (win_addr == '0));
            rf_wa    <= win_addr;
            rf_wd    <= win_data;
            grant_id <= win;
            ptr      <= ptr_nxt;
          end else begin
            rf_we <= 1'b0;
          end
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

endmodule
